// File: rtl/problem_2_inverse.sv
`default_nettype none
// problem_2_inverse: scans ABCD 0..15 and streams every input whose Problem_2 output {Y1,Y2}
// equals the captured target, then pulses done with the match count. Rev 1.0.
module problem_2_inverse (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] target,
   output logic       busy,
   output logic       m_valid,
   output logic [3:0] m_abcd,
   input  logic       m_ready,
   output logic       done,
   output logic [4:0] match_count
);

   // Truth table of the forward function, one bit per ABCD value
   localparam logic [15:0] Y1_MASK = 16'h38F0;
   localparam logic [15:0] Y2_MASK = 16'h0036;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_EMIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [1:0] target_q, target_d;
   logic [3:0] abcd_q, abcd_d;
   logic [4:0] count_q, count_d;
   logic       hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= 4'd0;
         target_q <= 2'b00;
         abcd_q   <= 4'd0;
         count_q  <= 5'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         target_q <= target_d;
         abcd_q   <= abcd_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      target_d = target_q;
      abcd_d   = abcd_q;
      count_d  = count_q;
      hit      = ({Y1_MASK[idx_q], Y2_MASK[idx_q]} == target_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               target_d = target;
               idx_d    = 4'd0;
               count_d  = 5'd0;
               state_d  = S_SCAN;
            end
         end
         S_SCAN: begin
            if (hit) begin
               abcd_d  = idx_q;
               count_d = count_q + 5'd1;
               state_d = S_EMIT;
            end else if (idx_q == 4'd15) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         S_EMIT: begin
            // idx is never advanced past 15, so the last candidate goes straight to DONE
            if (m_ready) begin
               if (idx_q == 4'd15) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_SCAN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign m_valid     = (state_q == S_EMIT);
   assign done        = (state_q == S_DONE);
   assign m_abcd      = abcd_q;
   assign match_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_problem_2_inverse.sv
`default_nettype none
// tb_problem_2_inverse: directed scans checked against a set-membership model of the function.
module tb_problem_2_inverse;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] target = 2'b00;
   logic       m_ready = 1'b1;
   logic       busy, m_valid, done;
   logic [3:0] m_abcd;
   logic [4:0] match_count;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int exp_q[$];
   int exp_count = 0;
   int emitted[$];
   logic [15:0] seen = 16'h0;
   int repeats = 0;
   bit stalled = 1'b0;
   int held = 0;

   problem_2_inverse dut (
      .clk(clk), .rst(rst), .start(start), .target(target), .busy(busy),
      .m_valid(m_valid), .m_abcd(m_abcd), .m_ready(m_ready), .done(done),
      .match_count(match_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
   endtask

   function automatic logic [1:0] ref_f(input int v);
      logic y1, y2;
      y1 = (v inside {4, 5, 6, 7, 11, 12, 13});
      y2 = (v inside {1, 2, 4, 5});
      return {y1, y2};
   endfunction

   task automatic load_model(input logic [1:0] t);
      exp_q.delete();
      exp_count = 0;
      for (int v = 0; v < 16; v++) begin
         if (ref_f(v) == t) begin
            exp_q.push_back(v);
            exp_count++;
         end
      end
   endtask

   // Compare process: every handshake and every done pulse is checked against the model
   always @(negedge clk) begin
      #2;
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (m_valid) begin
            if (stalled) check("hold_stable", int'(m_abcd), held);
            if (m_ready) begin
               check("emit_pending", (exp_q.size() > 0) ? 1 : 0, 1);
               if (exp_q.size() > 0) check("emit_value", int'(m_abcd), exp_q.pop_front());
               if (seen[m_abcd]) repeats++;
               seen[m_abcd] = 1'b1;
               emitted.push_back(int'(m_abcd));
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = int'(m_abcd);
            end
         end else begin
            stalled = 1'b0;
         end
         if (done) begin
            check("done_count", int'(match_count), exp_count);
            check("done_leftover", exp_q.size(), 0);
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at the negedge of cycle 18+k+stalls
   task automatic run_scan(input logic [1:0] tgt, input int stall, input bit glitch,
                           output int dcyc, output int cnt);
      int t0, waited, g;
      waited = 0;
      g = 0;
      start = 1'b1;
      target = tgt;
      load_model(tgt);
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
      while (!done && g < 400) begin
         if (glitch && g == 1) begin
            start = 1'b1;
            target = ~tgt;
         end else begin
            start = 1'b0;
         end
         if (m_valid) begin
            if (waited < stall) begin
               m_ready = 1'b0;
               waited++;
            end else begin
               m_ready = 1'b1;
               waited = 0;
            end
         end else begin
            m_ready = 1'b1;
         end
         @(negedge clk);
         g++;
      end
      check("done_seen", int'(done), 1);
      dcyc = cyc - t0;
      cnt = int'(match_count);
      @(negedge clk);
      start = 1'b0;
      m_ready = 1'b1;
      check("busy_after_done", int'(busy), 0);
      check("done_one_cycle", int'(done), 0);
   endtask

   initial begin
      int dcyc, cnt, g, dones;
      int exp_cnt[4];
      int exp_cyc[4];
      exp_cnt = '{7, 2, 5, 2};
      exp_cyc = '{24, 19, 22, 19};

      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(m_valid), 0);
      check("rst_abcd", int'(m_abcd), 0);
      check("rst_done", int'(done), 0);
      check("rst_count", int'(match_count), 0);
      rst = 1'b0;

      // Target 01 with m_ready high
      emitted.delete();
      run_scan(2'b01, 0, 1'b0, dcyc, cnt);
      check("t01_done_cycle", dcyc, 19);
      check("t01_count", cnt, 2);
      check("t01_n_emitted", emitted.size(), 2);
      if (emitted.size() == 2) begin
         check("t01_first", emitted[0], 1);
         check("t01_second", emitted[1], 2);
      end

      // Back-to-back sweep of all targets
      emitted.delete();
      seen = 16'h0;
      repeats = 0;
      for (int t = 0; t < 4; t++) begin
         run_scan(t[1:0], 0, 1'b0, dcyc, cnt);
         check("sweep_count", cnt, exp_cnt[t]);
         check("sweep_done_cycle", dcyc, exp_cyc[t]);
      end
      check("sweep_total", emitted.size(), 16);
      check("sweep_repeats", repeats, 0);
      check("sweep_coverage", int'(seen), 32'hFFFF);

      // Backpressure: 3 stall cycles per match
      run_scan(2'b10, 3, 1'b0, dcyc, cnt);
      check("bp_done_cycle", dcyc, 37);
      check("bp_count", cnt, 5);

      // Target 00: last match on idx 15
      emitted.delete();
      run_scan(2'b00, 0, 1'b0, dcyc, cnt);
      check("t00_done_cycle", dcyc, 24);
      check("t00_count", cnt, 7);
      if (emitted.size() > 0) check("t00_last", emitted[emitted.size()-1], 15);
      else check("t00_last_present", 0, 1);

      // Start pulse and target change while busy are ignored
      run_scan(2'b01, 0, 1'b1, dcyc, cnt);
      check("glitch_done_cycle", dcyc, 19);
      check("glitch_count", cnt, 2);

      // Reset during EMIT at idx 11 for target 10
      load_model(2'b10);
      start = 1'b1;
      target = 2'b10;
      @(negedge clk);
      start = 1'b0;
      g = 0;
      while (!(m_valid && m_abcd == 4'd11) && g < 100) begin
         m_ready = 1'b1;
         @(negedge clk);
         g++;
      end
      check("abort_reached_11", (m_valid && m_abcd == 4'd11) ? 1 : 0, 1);
      m_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      m_ready = 1'b1;
      check("abort_valid", int'(m_valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_count", int'(match_count), 0);
      check("abort_abcd", int'(m_abcd), 0);
      dones = int'(done);
      repeat (20) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      emitted.delete();
      run_scan(2'b11, 0, 1'b0, dcyc, cnt);
      check("after_abort_count", cnt, 2);
      check("after_abort_done_cycle", dcyc, 19);
      if (emitted.size() == 2) begin
         check("after_abort_first", emitted[0], 4);
         check("after_abort_second", emitted[1], 5);
      end else begin
         check("after_abort_n_emitted", emitted.size(), 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/problem_2_inverse.md
# problem_2_inverse

Sequential inverse of the Problem_2 four-input logic function: given a target output pair {Y1, Y2}, the block scans all 16 input combinations {A,B,C,D} in ascending order and emits every combination that produces the target. Matches leave on a valid/ready stream, followed by a done pulse carrying the match count. It is the decoder/preimage side of the Problem_2 encoder and is used to cross-check that function in the homework test benches.

## Interface
- No parameters; all widths are fixed by the 4-in/2-out function.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a scan; sampled only in IDLE.
- target  input  2  {Y1, Y2} to invert; captured on an accepted start.
- busy  output  1  high in every state except IDLE.
- m_valid  output  1  a matching input combination is presented.
- m_abcd  output  4  matching {A,B,C,D}, with A as the MSB.
- m_ready  input  1  consumer accepts m_abcd.
- done  output  1  one-cycle pulse at scan completion.
- match_count  output  5  number of matches in the last scan, 0..16.

## Operation
- Internal function, fixed:
  - Y1 = 1 for ABCD ∈ {4,5,6,7,11,12,13}.
  - Y2 = 1 for ABCD ∈ {1,2,4,5}.
- Preimage sets:
  - target 00 -> {0,3,8,9,10,14,15}, 7 matches.
  - target 01 -> {1,2}, 2 matches.
  - target 10 -> {6,7,11,12,13}, 5 matches.
  - target 11 -> {4,5}, 2 matches.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - start=1 latches target, clears idx (4 bits) and match_count, and moves to SCAN.
  - start=0 stays in IDLE.
- SCAN evaluates the function at idx each cycle.
  - On a match: register m_abcd=idx, set m_valid=1, increment match_count, go to EMIT.
  - No match with idx<15: idx+1, stay in SCAN.
  - No match with idx==15: go to DONE.
- EMIT holds m_valid and m_abcd stable until m_ready=1.
  - On the handshake cycle with idx<15: idx+1, go to SCAN.
  - On the handshake cycle with idx==15: go to DONE.
  - m_valid drops on the edge after the handshake.
- DONE: done=1 for exactly one cycle, then IDLE.
- match_count holds its value from DONE until the next accepted start.
- idx never wraps: the 15->0 transition does not occur inside a scan.
- start while busy=1 is ignored and not queued.
- target changes after capture have no effect on the running scan.
- m_ready while m_valid=0 is ignored.

## Timing
- Reset values, applied on the rst edge: state IDLE, busy=0, m_valid=0, m_abcd=0, done=0, match_count=0, idx=0, captured target=00.
- rst in any state, including EMIT with m_valid=1, aborts the scan and restores reset values on the next edge. No done pulse is produced.
- rst has priority over start in the same cycle.
- Cycle numbering: start is sampled at the edge ending cycle 0.
  - Cycle 1 is SCAN at idx 0, and busy=1 from cycle 1.
- Each SCAN cycle covers one candidate. Each EMIT cycle adds 1 cycle plus any m_ready stall cycles.
- With m_ready held high and k matches, done is high in cycle 17+k and busy=0 from cycle 18+k.
- A new start is accepted in cycle 18+k at the earliest.
- The first match is presented the cycle after its SCAN cycle; latency from evaluation to m_valid is 1 cycle.

## Test plan
- Reset, then target=01 with start pulsed and m_ready=1:
  - m_abcd presents 1 then 2, each for one cycle.
  - done is high in cycle 19 and match_count=2.
- Sweep all four targets back-to-back, each start issued right after done:
  - emitted sets are {0,3,8,9,10,14,15}, {1,2}, {6,7,11,12,13} and {4,5}.
  - match_count is 7, 2, 5 and 2.
  - total emitted across the sweep = 16, with no repeats.
- Backpressure: target=10 with m_ready low for 3 cycles on every match:
  - m_abcd stable while stalled; the same 5 values are emitted in order.
  - done in cycle 17+5+15=37.
- target=00, whose last match is idx 15:
  - after the handshake on 15, DONE follows directly, done=1 and match_count=7.
- Pulse start again and change target while busy:
  - no restart; results are those of the original target.
- Assert rst during EMIT at idx 11 (target 10):
  - next cycle m_valid=0, busy=0, match_count=0, and no done pulse.
  - a following start with target 11 yields {4,5} and count 2.
